// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin front end sharing one saturating add/sub unit between two requesters.
// Optional ARB_STATS_EN adds saturating grant and conflict counters.
module addsub_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_flags,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
`ifdef ARB_STATS_EN
    output logic [7:0]       grant0_cnt,
    output logic [7:0]       grant1_cnt,
    output logic [7:0]       conflict_cnt,
`endif
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_n,
    input  logic             add_z,
    input  logic             add_v
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t r_state, w_next;
    logic   r_owner;
    logic   r_last;
    logic   w_hs;
    logic   w_rsp_acc;
    assign w_hs      = req0_ready | req1_ready;
    assign w_rsp_acc = (r_state == RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE && w_hs) ? EXEC :
                 (r_state == EXEC)         ? RESP :
                 w_rsp_acc                 ? IDLE : r_state;
    end
    // r_last names the requester granted most recently; it loses the next tie.
    always_comb begin
        req0_ready = (r_state == IDLE) && !rst && req0_valid && (!req1_valid || r_last);
        req1_ready = (r_state == IDLE) && !rst && req1_valid && (!req0_valid || !r_last);
        rsp0_valid = (r_state == RESP) && !r_owner;
        rsp1_valid = (r_state == RESP) && r_owner;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a     <= '0;
            add_b     <= '0;
            add_sub   <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= 3'b000;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            if (w_hs) begin
                add_a   <= req1_ready ? req1_a : req0_a;
                add_b   <= req1_ready ? req1_b : req0_b;
                add_sub <= req1_ready ? req1_sub : req0_sub;
                r_owner <= req1_ready;
                r_last  <= req1_ready;
            end
            if (r_state == EXEC) begin
                rsp_data  <= add_sum;
                rsp_flags <= {add_n, add_z, add_v};
            end
        end
    end
`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt   <= 8'd0;
            grant1_cnt   <= 8'd0;
            conflict_cnt <= 8'd0;
        end else begin
            if (req0_ready && grant0_cnt != 8'hFF) grant0_cnt <= grant0_cnt + 8'd1;
            if (req1_ready && grant1_cnt != 8'hFF) grant1_cnt <= grant1_cnt + 8'd1;
            if (r_state == IDLE && req0_valid && req1_valid && conflict_cnt != 8'hFF)
                conflict_cnt <= conflict_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: randomized and directed checks of addsub_arbiter against a transaction-level model.
module tb_addsub_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_sub, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_sub, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp_data, add_a, add_b, add_sum;
    logic [2:0]  rsp_flags;
    logic        add_sub, add_n, add_z, add_v;
`ifdef ARB_STATS_EN
    logic [7:0]  grant0_cnt, grant1_cnt, conflict_cnt;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Saturating signed add/sub: returns {result, N, Z, V}.
    function automatic logic [18:0] sat_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        int          r;
        logic [31:0] rv;
        logic [15:0] res;
        logic        v;
        r   = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
        v   = (r > 32767) || (r < -32768);
        rv  = r;
        res = v ? ((r > 0) ? 16'h7FFF : 16'h8000) : rv[15:0];
        return {res, res[15], res == 16'h0000, v};
    endfunction

    assign {add_sum, add_n, add_z, add_v} = sat_op(add_a, add_b, add_sub);

    addsub_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
`ifdef ARB_STATS_EN
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .conflict_cnt(conflict_cnt),
`endif
        .add_sum(add_sum), .add_n(add_n), .add_z(add_z), .add_v(add_v)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: one outstanding op, its age in cycles since the grant, and the tie-break memory.
    logic        m_busy = 1'b0;
    int          m_age = 0;
    logic        m_owner = 1'b0;
    logic        m_last = 1'b1;
    logic [15:0] m_a, m_b;
    logic        m_s;
    logic [18:0] m_exp;
    logic        zero_chk = 1'b0;
    int          m_g0 = 0, m_g1 = 0, m_cf = 0;

    task automatic step();
        logic e0, e1, rv;
        @(negedge clk);
        if (zero_chk) begin
            chk("rst_data", rsp_data, 0);
            chk("rst_flags", rsp_flags, 0);
            chk("rst_add_a", add_a, 0);
            chk("rst_add_b", add_b, 0);
            chk("rst_add_sub", add_sub, 0);
            zero_chk = 1'b0;
        end
        e0 = !rst && !m_busy && req0_valid && (!req1_valid || m_last);
        e1 = !rst && !m_busy && req1_valid && (!req0_valid || !m_last);
        rv = m_busy && m_age == 2;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("rsp0_valid", rsp0_valid, rv && !m_owner);
        chk("rsp1_valid", rsp1_valid, rv && m_owner);
        if (m_busy) begin
            chk("add_a", add_a, m_a);
            chk("add_b", add_b, m_b);
            chk("add_sub", add_sub, m_s);
        end
        if (rv) begin
            chk("rsp_data", rsp_data, m_exp[18:3]);
            chk("rsp_flags", rsp_flags, m_exp[2:0]);
        end
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; zero_chk = 1'b1;
            m_g0 = 0; m_g1 = 0; m_cf = 0;
        end else begin
            if (!m_busy && req0_valid && req1_valid && m_cf < 255) m_cf++;
            if (e0 || e1) begin
                m_busy = 1'b1; m_age = 1; m_owner = e1; m_last = e1;
                m_a = e1 ? req1_a : req0_a;
                m_b = e1 ? req1_b : req0_b;
                m_s = e1 ? req1_sub : req0_sub;
                m_exp = sat_op(m_a, m_b, m_s);
                if (e0 && m_g0 < 255) m_g0++;
                if (e1 && m_g1 < 255) m_g1++;
            end else if (m_busy && m_age == 1) m_age = 2;
            else if (rv && (m_owner ? rsp1_ready : rsp0_ready)) m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // single add
        req0_valid = 1; req0_a = 16'd20000; req0_b = 16'd10000; req0_sub = 0;
        step();
        req0_valid = 0;
        repeat (3) step();
        // contention, alternation, then a third contention that goes back to req0
        do_reset();
        req0_valid = 1; req0_a = 16'd20000; req0_b = 16'd10000; req0_sub = 1;
        req1_valid = 1; req1_a = 16'd5; req1_b = 16'd7; req1_sub = 1;
        repeat (9) step();
        req0_valid = 0; req1_valid = 0;
        repeat (2) step();
        // saturation passthrough
        req1_valid = 1; req1_a = 16'd32767; req1_b = 16'd100; req1_sub = 0;
        step();
        req1_valid = 0;
        repeat (3) step();
        req1_valid = 1; req1_a = 16'h8001; req1_b = 16'hFB2E; req1_sub = 0;
        step();
        req1_valid = 0;
        repeat (3) step();
        // response backpressure with req1 waiting
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h0F0F; req0_sub = 1;
        req1_valid = 1; req1_a = 16'h0001; req1_b = 16'h0002; req1_sub = 0;
        step();
        req0_valid = 0;
        repeat (6) step();
        rsp0_ready = 1;
        repeat (4) step();
        req1_valid = 0;
        repeat (2) step();
        // reset during EXEC
        req0_valid = 1; req0_a = 16'h4000; req0_b = 16'h4000; req0_sub = 0;
        step();
        req0_valid = 0;
        rst = 1;
        step();
        rst = 0;
        repeat (3) step();
        req0_valid = 1; req1_valid = 1;
        repeat (3) step();
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            req0_valid = !rst && ($urandom_range(0, 2) != 0);
            req1_valid = !rst && ($urandom_range(0, 2) != 0);
            req0_a = 16'($urandom); req0_b = 16'($urandom); req0_sub = 1'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sub = 1'($urandom);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();
`ifdef ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            req0_valid = 1; req0_a = 16'(i); req0_b = 16'd3; req0_sub = 0;
            repeat (3) step();
        end
        req0_valid = 0;
        repeat (2) step();
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1; req1_valid = 1;
            step();
            req0_valid = 0; req1_valid = 0;
            repeat (3) step();
        end
        @(negedge clk);
        chk("grant0_cnt", grant0_cnt, m_g0);
        chk("grant1_cnt", grant1_cnt, m_g1);
        chk("conflict_cnt", conflict_cnt, m_cf);
        chk("grant0_sat", grant0_cnt, 255);
        chk("conflict_two", conflict_cnt, 2);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Two-requester controller that shares the single 16-bit saturating add/sub datapath.
- Requester 0 is the ALU execute path; requester 1 is the address/branch-target path.
- Accepts one operation at a time with a valid/ready handshake and registers the operands onto the shared adder.
- Captures the sum and N/Z/V flags, then returns them on the granted requester's response channel.
- Arbitration is round-robin.

Parameters:
- WIDTH, 16: operand/result width; must match the shared adder.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 operation valid
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_sub  in  1  requester 0 op: 0=A+B, 1=A-B
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_sub, req1_ready: same as requester 0, for requester 1
- rsp0_valid  out  1  response for requester 0 available
- rsp1_valid  out  1  response for requester 1 available
- rsp0_ready  in  1  requester 0 consumes response
- rsp1_ready  in  1  requester 1 consumes response
- rsp_data  out  WIDTH  captured saturated result, shared by both channels
- rsp_flags  out  3  captured {N,Z,V}
- add_a  out  WIDTH  registered operand A to the shared adder
- add_b  out  WIDTH  registered operand B to the shared adder
- add_sub  out  1  registered op select to the shared adder
- add_sum  in  WIDTH  adder result, combinational from add_*
- add_n  in  1  adder N flag
- add_z  in  1  adder Z flag
- add_v  in  1  adder V flag

Behaviour:
- Reset: all outputs to 0; state IDLE; round-robin pointer favours req0. Reset wins over every other event.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational: high only for the requester that is valid and wins arbitration.
  - At most one ready is high per cycle.
  - Arbitration: only one valid → grant it. Both valid → grant the requester not granted last.
  - On handshake (valid & ready): latch a/b/sub into add_a/add_b/add_sub, record the owner, update the pointer to the owner, go to EXEC.
- EXEC: exactly one cycle, adder settles. At the clock edge, capture add_sum into rsp_data and {add_n,add_z,add_v} into rsp_flags, then go to RESP.
- RESP:
  - rspX_valid is high only for the owner.
  - rsp_data and rsp_flags stay stable until rspX_ready is sampled high.
  - On acceptance, drop rspX_valid next cycle and return to IDLE.
  - No new grant is issued while in RESP.
- Latency: handshake at edge t, result visible with rspX_valid at t+2. Back-to-back throughput is one op per 3 cycles when rsp_ready is held high.
- Response ready:
  - rsp_ready of the non-owner is ignored.
  - rsp_ready high in IDLE/EXEC has no effect.
- add_a/add_b/add_sub hold their last values outside EXEC; they are not cleared.
- Arithmetic: the controller passes the adder result and flags through unmodified. Saturation is owned by the adder.
- Requester rules: a requester may drop valid before it is granted, with no state change. Operand changes after the handshake are ignored.
- Reset mid-operation (EXEC or RESP): the pending result is discarded and no response is issued for it.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds outputs:
  - grant0_cnt, 8 bits: handshakes on requester 0.
  - grant1_cnt, 8 bits: handshakes on requester 1.
  - conflict_cnt, 8 bits: IDLE cycles with both valid high.
- Counters saturate at 255 (no wrap) and clear on rst.
- When not defined: the ports and logic are absent; the behaviour above is otherwise identical.

Test Plan:
- Single add:
  - Stimulus: req0 a=20000, b=10000, sub=0 from IDLE; rsp0_ready=1.
  - Response: req0_ready high in cycle t; rsp0_valid at t+2; rsp_data=30000; flags=000; rsp1_valid stays 0.
- Simultaneous contention:
  - Stimulus: after reset, req0 and req1 both valid and held; req0 a=20000, b=10000, sub=1; req1 a=5, b=7, sub=1.
  - Response: req0 granted first, rsp_data=10000; then req1 granted, rsp_data=0xFFFE, flags N=1.
  - Next contention grants req0 again (alternation).
- Saturation passthrough:
  - Stimulus: req1 a=32767, b=100, sub=0.
  - Response: rsp_data=0x7FFF, V=1.
  - Stimulus: a=0x8001, b=0xFB2E, sub=0.
  - Response: rsp_data=0x8000, N=1, V=1.
- Response backpressure:
  - Stimulus: rsp0_ready low for 5 cycles in RESP; req1_valid high meanwhile.
  - Response: rsp_data/flags stable; req1_ready stays 0.
  - After rsp0_ready=1: IDLE, then req1 is granted on the next cycle.
- Reset mid-op:
  - Stimulus: assert rst during EXEC.
  - Response: next cycle all outputs 0; no rsp_valid ever appears for the aborted op; the next contention grants req0.
- With ARB_STATS_EN:
  - Stimulus: 300 back-to-back req0 ops, plus 2 contention cycles.
  - Response: grant0_cnt=255 (saturated); conflict_cnt=2.
